// File: rtl/op_decode_stage.sv
// op_decode_stage: registered instruction-decode stage between the fetch/operand
// front end and the IE ALU/sequencer.
//
// Each accepted instruction is classified, its ALU A/B/destination source codes are
// resolved, and it is expanded into 1..4 micro-ops. The micro-ops are queued in a
// DEPTH-entry FIFO whose head drives the out_* bus.
//
// Handshake (both sides): a transfer happens on a rising clk edge where valid and
// ready are both high. in_ready is IDLE && !fifo_full && !flush; the consumer pops
// the head when out_valid && out_ready. While the FIFO is empty all out_* data are 0.
//
// Optional build macro: DECODE_PERF_EN adds perf_insn_cnt / perf_stall_cnt.
//
// Source/destination code map used on out_alu_a/b/dst:
//   0 zero, 1 mem_load, 2 a_reg, 3 x_reg, 4 y_reg, 5 status_reg, 6 stack_reg,
//   7 one, 8 imm, 9 mem_store
// Branch op-codes: BCC 03, BCS 04, BEQ 05, BMI 07, BNE 08, BPL 09, BVC 0A,
//   BVS 0B, JMP 1C.
module op_decode_stage #(
    parameter int OP_W   = 8,
    parameter int FLAG_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   simple_op,
    input  logic              mem_load_flag,
    input  logic [2:0]        store_flag,
    input  logic [1:0]        reg_load_flag,
    input  logic [3:0]        alu_op_in,
    input  logic              immediate_flag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [9:0]        out_class,
    output logic [FLAG_W-1:0] out_alu_a,
    output logic [FLAG_W-1:0] out_alu_b,
    output logic [FLAG_W-1:0] out_alu_dst,
    output logic [3:0]        out_alu_op,
    output logic [FLAG_W-1:0] out_status_edit,
    output logic [1:0]        out_uop_idx,
    output logic              out_uop_last,
`ifdef DECODE_PERF_EN
    output logic [15:0]       perf_insn_cnt,
    output logic [15:0]       perf_stall_cnt,
`endif
    output logic              dbg_state
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    localparam logic [FLAG_W-1:0] SRC_ZERO      = FLAG_W'(8'd0);
    localparam logic [FLAG_W-1:0] SRC_MEM_LOAD  = FLAG_W'(8'd1);
    localparam logic [FLAG_W-1:0] SRC_A_REG     = FLAG_W'(8'd2);
    localparam logic [FLAG_W-1:0] SRC_X_REG     = FLAG_W'(8'd3);
    localparam logic [FLAG_W-1:0] SRC_Y_REG     = FLAG_W'(8'd4);
    localparam logic [FLAG_W-1:0] SRC_STATUS    = FLAG_W'(8'd5);
    localparam logic [FLAG_W-1:0] SRC_STACK     = FLAG_W'(8'd6);
    localparam logic [FLAG_W-1:0] SRC_ONE       = FLAG_W'(8'd7);
    localparam logic [FLAG_W-1:0] SRC_IMM       = FLAG_W'(8'd8);
    localparam logic [FLAG_W-1:0] SRC_MEM_STORE = FLAG_W'(8'd9);
    localparam logic [FLAG_W-1:0] STATUS_MASK   = FLAG_W'(8'b1000_0010);

    localparam logic [OP_W-1:0] OP_BCC = OP_W'(8'h03);
    localparam logic [OP_W-1:0] OP_BCS = OP_W'(8'h04);
    localparam logic [OP_W-1:0] OP_BEQ = OP_W'(8'h05);
    localparam logic [OP_W-1:0] OP_BMI = OP_W'(8'h07);
    localparam logic [OP_W-1:0] OP_BNE = OP_W'(8'h08);
    localparam logic [OP_W-1:0] OP_BPL = OP_W'(8'h09);
    localparam logic [OP_W-1:0] OP_BVC = OP_W'(8'h0A);
    localparam logic [OP_W-1:0] OP_BVS = OP_W'(8'h0B);
    localparam logic [OP_W-1:0] OP_BRK = OP_W'(8'h0C);
    localparam logic [OP_W-1:0] OP_JMP = OP_W'(8'h1C);
    localparam logic [OP_W-1:0] OP_JSR = OP_W'(8'h1D);
    localparam logic [OP_W-1:0] OP_RTI = OP_W'(8'h2A);
    localparam logic [OP_W-1:0] OP_RTS = OP_W'(8'h2B);
    localparam logic [OP_W-1:0] OP_PHP = OP_W'(8'h25);
    localparam logic [OP_W-1:0] OP_TSX = OP_W'(8'h36);

    // Class vector bit positions
    localparam int C_LOAD   = 0;
    localparam int C_STORE  = 1;
    localparam int C_BRANCH = 2;
    localparam int C_JSR    = 3;
    localparam int C_RTS    = 4;
    localparam int C_RTI    = 5;
    localparam int C_BREAK  = 6;
    localparam int C_STACK  = 7;
    localparam int C_NOP    = 8;
    localparam int C_FLAG   = 9;

    typedef struct packed {
        logic [9:0]        cls;
        logic [FLAG_W-1:0] a;
        logic [FLAG_W-1:0] b;
        logic [FLAG_W-1:0] dst;
        logic [3:0]        op;
        logic [1:0]        idx;
        logic              last;
    } uop_t;

    typedef enum logic {S_IDLE, S_EXPAND} state_t;

    state_t            st;
    logic [9:0]        ex_cls;
    logic [3:0]        ex_op;
    logic [2:0]        ex_len;
    logic [1:0]        ex_idx;

    logic [9:0]        dec_cls;
    logic [FLAG_W-1:0] dec_a;
    logic [FLAG_W-1:0] dec_b;
    logic [FLAG_W-1:0] dec_dst;
    logic [2:0]        dec_len;
    logic              is_branch;

    uop_t              uop0;
    uop_t              exp_uop;
    uop_t              push_data;
    uop_t              head;
    uop_t              mem [DEPTH];

    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [CW-1:0]     count;
    logic              fifo_full;
    logic              accept;
    logic              exp_push;
    logic              push;
    logic              pop;
    logic              exp_is_last;

    // Combinational decode of the instruction presented on the input side
    always_comb begin
        is_branch = (simple_op == OP_BCC) || (simple_op == OP_BCS) ||
                    (simple_op == OP_BEQ) || (simple_op == OP_BMI) ||
                    (simple_op == OP_BNE) || (simple_op == OP_BPL) ||
                    (simple_op == OP_BVC) || (simple_op == OP_BVS) ||
                    (simple_op == OP_JMP);

        dec_cls           = '0;
        dec_cls[C_LOAD]   = mem_load_flag;
        dec_cls[C_STORE]  = (store_flag == 3'b001);
        dec_cls[C_BRANCH] = is_branch;
        dec_cls[C_JSR]    = (simple_op == OP_JSR);
        dec_cls[C_RTS]    = (simple_op == OP_RTS);
        dec_cls[C_RTI]    = (simple_op == OP_RTI);
        dec_cls[C_BREAK]  = (simple_op == OP_BRK);
        dec_cls[C_STACK]  = (simple_op >= OP_W'(8'h24)) && (simple_op <= OP_W'(8'h27));
        dec_cls[C_NOP]    = (simple_op == OP_W'(8'h18)) || (simple_op == OP_W'(8'h22));
        dec_cls[C_FLAG]   = ((simple_op >= OP_W'(8'h0D)) && (simple_op <= OP_W'(8'h10))) ||
                            ((simple_op >= OP_W'(8'h2E)) && (simple_op <= OP_W'(8'h30)));

        if (simple_op == OP_PHP) begin
            dec_a = SRC_STATUS;
        end else if (simple_op == OP_TSX) begin
            dec_a = SRC_STACK;
        end else begin
            case (reg_load_flag)
                2'b00:   dec_a = SRC_MEM_LOAD;
                2'b01:   dec_a = SRC_A_REG;
                2'b10:   dec_a = SRC_X_REG;
                default: dec_a = SRC_Y_REG;
            endcase
        end

        case (store_flag)
            3'b001:  dec_dst = SRC_MEM_STORE;
            3'b010:  dec_dst = SRC_A_REG;
            3'b011:  dec_dst = SRC_X_REG;
            3'b100:  dec_dst = SRC_Y_REG;
            3'b110:  dec_dst = SRC_STACK;
            3'b111:  dec_dst = SRC_STATUS;
            default: dec_dst = SRC_ZERO;
        endcase

        // Read-modify-write on the same location uses the constant one as B
        if (immediate_flag) begin
            dec_b = SRC_IMM;
        end else if (((dec_a == dec_dst) ||
                      ((dec_a == SRC_MEM_LOAD) && (dec_dst == SRC_MEM_STORE))) &&
                     (dec_a != SRC_A_REG)) begin
            dec_b = SRC_ONE;
        end else if (mem_load_flag && (dec_a == SRC_A_REG)) begin
            dec_b = SRC_MEM_LOAD;
        end else if ((simple_op == OP_W'(8'h12)) || (simple_op == OP_W'(8'h13))) begin
            dec_b = SRC_MEM_LOAD;
        end else begin
            dec_b = SRC_ZERO;
        end

        if (dec_cls[C_BREAK]) begin
            dec_len = 3'd4;
        end else if (dec_cls[C_JSR] || dec_cls[C_RTI]) begin
            dec_len = 3'd3;
        end else if (dec_cls[C_RTS]) begin
            dec_len = 3'd2;
        end else begin
            dec_len = 3'd1;
        end
    end

    // Micro-op candidates: first micro-op from live decode, later ones from latched state
    always_comb begin
        uop0.cls  = dec_cls;
        uop0.a    = dec_a;
        uop0.b    = dec_b;
        uop0.dst  = dec_dst;
        uop0.op   = alu_op_in;
        uop0.idx  = 2'd0;
        uop0.last = (dec_len == 3'd1);

        exp_is_last  = ({1'b0, ex_idx} == (ex_len - 3'd1));
        exp_uop.cls  = ex_cls;
        exp_uop.a    = SRC_STACK;
        exp_uop.b    = SRC_ONE;
        exp_uop.dst  = SRC_STACK;
        exp_uop.op   = ex_op;
        exp_uop.idx  = ex_idx;
        exp_uop.last = exp_is_last;
    end

    assign fifo_full = (count == CW'(DEPTH));
    assign in_ready  = (st == S_IDLE) && !fifo_full && !flush;
    assign accept    = in_valid && in_ready;
    assign exp_push  = (st == S_EXPAND) && !fifo_full && !flush;
    assign push      = accept || exp_push;
    assign push_data = accept ? uop0 : exp_uop;
    assign out_valid = (count != '0);
    assign pop       = out_valid && out_ready && !flush;
    assign dbg_state = st;

    // Expansion sequencer: IDLE accepts instructions, EXPAND emits the remaining micro-ops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= S_IDLE;
            ex_cls <= '0;
            ex_op  <= '0;
            ex_len <= '0;
            ex_idx <= '0;
        end else if (flush) begin
            st <= S_IDLE;
        end else begin
            case (st)
                S_IDLE: begin
                    if (accept && (dec_len != 3'd1)) begin
                        ex_cls <= dec_cls;
                        ex_op  <= alu_op_in;
                        ex_len <= dec_len;
                        ex_idx <= 2'd1;
                        st     <= S_EXPAND;
                    end
                end
                S_EXPAND: begin
                    if (!fifo_full) begin
                        if (exp_is_last) begin
                            st <= S_IDLE;
                        end else begin
                            ex_idx <= ex_idx + 2'd1;
                        end
                    end
                end
                default: st <= S_IDLE;
            endcase
        end
    end

    // FIFO pointers and occupancy; flush empties the queue
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are only observable through a valid head
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= push_data;
        end
    end

    assign head            = mem[rptr];
    assign out_class       = out_valid ? head.cls  : '0;
    assign out_alu_a       = out_valid ? head.a    : '0;
    assign out_alu_b       = out_valid ? head.b    : '0;
    assign out_alu_dst     = out_valid ? head.dst  : '0;
    assign out_alu_op      = out_valid ? head.op   : '0;
    assign out_uop_idx     = out_valid ? head.idx  : '0;
    assign out_uop_last    = out_valid ? head.last : 1'b0;
    assign out_status_edit = out_valid ? STATUS_MASK : '0;

`ifdef DECODE_PERF_EN
    // Saturating activity counters; survive flush, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_insn_cnt  <= '0;
            perf_stall_cnt <= '0;
        end else begin
            if (accept && (perf_insn_cnt != 16'hFFFF)) begin
                perf_insn_cnt <= perf_insn_cnt + 16'd1;
            end
            if (in_valid && !in_ready && (perf_stall_cnt != 16'hFFFF)) begin
                perf_stall_cnt <= perf_stall_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_op_decode_stage.sv
// tb_op_decode_stage: directed scenarios plus randomized traffic for op_decode_stage,
// checked every cycle against a queue-based model of the decode rules.
module tb_op_decode_stage;

    localparam int DEPTH = 2;
    localparam int UW    = 41;

    localparam logic [7:0] S_ZERO = 8'd0, S_MEM_LOAD = 8'd1, S_A = 8'd2, S_X = 8'd3,
                           S_Y = 8'd4, S_STATUS = 8'd5, S_STACK = 8'd6, S_ONE = 8'd7,
                           S_IMM = 8'd8, S_MEM_STORE = 8'd9;

    logic       clk, rst, flush, in_valid, in_ready, mem_load_flag, immediate_flag;
    logic       out_valid, out_ready, out_uop_last, dbg_state;
    logic [7:0] simple_op, out_alu_a, out_alu_b, out_alu_dst, out_status_edit;
    logic [2:0] store_flag;
    logic [1:0] reg_load_flag, out_uop_idx;
    logic [3:0] alu_op_in, out_alu_op;
    logic [9:0] out_class;
`ifdef DECODE_PERF_EN
    logic [15:0] perf_insn_cnt, perf_stall_cnt;
    int          m_insn, m_stall;
`endif

    int checks   = 0;
    int failures = 0;

    logic [UW-1:0] fifo_q[$];
    logic [UW-1:0] pend_q[$];
    logic [UW-1:0] tmp_q[$];

    logic [7:0] op_tab [0:25] = '{8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h09, 8'h0A,
                                  8'h0B, 8'h1C, 8'h0C, 8'h0D, 8'h10, 8'h2E, 8'h30,
                                  8'h24, 8'h25, 8'h27, 8'h18, 8'h22, 8'h1D, 8'h2A,
                                  8'h2B, 8'h12, 8'h13, 8'h36, 8'h40};
    logic [7:0] dst_map [0:7] = '{S_ZERO, S_MEM_STORE, S_A, S_X, S_Y, S_ZERO, S_STACK, S_STATUS};

    op_decode_stage #(.OP_W(8), .FLAG_W(8), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .simple_op(simple_op), .mem_load_flag(mem_load_flag), .store_flag(store_flag),
        .reg_load_flag(reg_load_flag), .alu_op_in(alu_op_in), .immediate_flag(immediate_flag),
        .out_valid(out_valid), .out_ready(out_ready), .out_class(out_class),
        .out_alu_a(out_alu_a), .out_alu_b(out_alu_b), .out_alu_dst(out_alu_dst),
        .out_alu_op(out_alu_op), .out_status_edit(out_status_edit),
        .out_uop_idx(out_uop_idx), .out_uop_last(out_uop_last),
`ifdef DECODE_PERF_EN
        .perf_insn_cnt(perf_insn_cnt), .perf_stall_cnt(perf_stall_cnt),
`endif
        .dbg_state(dbg_state)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference decode rules
    function automatic logic [9:0] ref_class(input logic [7:0] op, input logic mem,
                                             input logic [2:0] st);
        logic [9:0] c;
        c    = '0;
        c[0] = mem;
        c[1] = (st == 3'b001);
        c[2] = op inside {8'h03, 8'h04, 8'h05, 8'h07, 8'h08, 8'h09, 8'h0A, 8'h0B, 8'h1C};
        c[3] = (op == 8'h1D);
        c[4] = (op == 8'h2B);
        c[5] = (op == 8'h2A);
        c[6] = (op == 8'h0C);
        c[7] = op inside {[8'h24:8'h27]};
        c[8] = op inside {8'h18, 8'h22};
        c[9] = op inside {[8'h0D:8'h10], [8'h2E:8'h30]};
        return c;
    endfunction

    function automatic int ref_len(input logic [7:0] op);
        case (op)
            8'h0C:        return 4;
            8'h1D, 8'h2A: return 3;
            8'h2B:        return 2;
            default:      return 1;
        endcase
    endfunction

    task automatic build(input logic [7:0] op, input logic mem, input logic [2:0] st,
                         input logic [1:0] rl, input logic [3:0] aop, input logic imm);
        logic [7:0] a, b, d;
        logic [9:0] c;
        int n;
        c = ref_class(op, mem, st);
        n = ref_len(op);
        if (op == 8'h25) a = S_STATUS;
        else if (op == 8'h36) a = S_STACK;
        else a = (rl == 2'd0) ? S_MEM_LOAD : (rl == 2'd1) ? S_A : (rl == 2'd2) ? S_X : S_Y;
        d = dst_map[st];
        if (imm) b = S_IMM;
        else if ((a == d || (a == S_MEM_LOAD && d == S_MEM_STORE)) && a != S_A) b = S_ONE;
        else if (mem && a == S_A) b = S_MEM_LOAD;
        else if (op == 8'h12 || op == 8'h13) b = S_MEM_LOAD;
        else b = S_ZERO;
        tmp_q.delete();
        for (int k = 0; k < n; k++) begin
            if (k == 0) tmp_q.push_back({c, a, b, d, aop, 2'(k), (n == 1)});
            else tmp_q.push_back({c, S_STACK, S_ONE, S_STACK, aop, 2'(k), (k == n - 1)});
        end
    endtask

    // One clock cycle: drive at negedge, check against model, advance model for next edge
    task automatic step(input logic v, input logic fl, input logic ordy, input logic [7:0] op,
                        input logic mem, input logic [2:0] st, input logic [1:0] rl,
                        input logic [3:0] aop, input logic imm);
        logic exp_rdy, acc, pop, have_push;
        logic [UW-1:0] pu, hexp, dump;
        @(negedge clk);
        in_valid = v; flush = fl; out_ready = ordy; simple_op = op; mem_load_flag = mem;
        store_flag = st; reg_load_flag = rl; alu_op_in = aop; immediate_flag = imm;
        #1;
        exp_rdy = (pend_q.size() == 0) && (fifo_q.size() < DEPTH) && !fl;
        hexp    = (fifo_q.size() > 0) ? fifo_q[0] : '0;
        check("in_ready", 64'(in_ready), 64'(exp_rdy));
        check("out_valid", 64'(out_valid), 64'(fifo_q.size() > 0));
        check("out_head", 64'({out_class, out_alu_a, out_alu_b, out_alu_dst, out_alu_op,
                              out_uop_idx, out_uop_last}), 64'(hexp));
        check("status_edit", 64'(out_status_edit), (fifo_q.size() > 0) ? 64'h82 : 64'h0);
`ifdef DECODE_PERF_EN
        check("perf_insn", 64'(perf_insn_cnt), 64'(m_insn));
        check("perf_stall", 64'(perf_stall_cnt), 64'(m_stall));
`endif
        acc = v && exp_rdy;
`ifdef DECODE_PERF_EN
        if (acc && m_insn < 65535) m_insn++;
        if (v && !exp_rdy && m_stall < 65535) m_stall++;
`endif
        if (fl) begin
            fifo_q.delete();
            pend_q.delete();
        end else begin
            pop       = (fifo_q.size() > 0) && ordy;
            have_push = 1'b0;
            pu        = '0;
            if (acc) begin
                build(op, mem, st, rl, aop, imm);
                pu = tmp_q.pop_front();
                have_push = 1'b1;
                pend_q = tmp_q;
            end else if (pend_q.size() > 0 && fifo_q.size() < DEPTH) begin
                pu = pend_q.pop_front();
                have_push = 1'b1;
            end
            if (pop) dump = fifo_q.pop_front();
            if (have_push) fifo_q.push_back(pu);
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b0, 1'b0, ordy, 8'h00, 1'b0, 3'b000, 2'b00, 4'h0, 1'b0);
    endtask

    task automatic clear_model();
        fifo_q.delete();
        pend_q.delete();
`ifdef DECODE_PERF_EN
        m_insn  = 0;
        m_stall = 0;
`endif
    endtask

    // Reset pulse asserted between edges; outputs must drop without a clock
    task automatic mid_reset();
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_out_data", 64'({out_class, out_alu_a, out_alu_b, out_alu_dst, out_alu_op,
                                  out_status_edit, out_uop_idx, out_uop_last}), 64'h0);
`ifdef DECODE_PERF_EN
        check("rst_perf", 64'({perf_insn_cnt, perf_stall_cnt}), 64'h0);
`endif
        clear_model();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Stimulus and final report
    initial begin
        logic v, fl, ordy, mem, imm;
        logic [7:0] op;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; simple_op = '0;
        mem_load_flag = 1'b0; store_flag = '0; reg_load_flag = '0; alu_op_in = '0;
        immediate_flag = 1'b0;
        clear_model();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_valid", 64'(out_valid), 64'h0);
        check("reset_ready", 64'(in_ready), 64'h1);
        check("reset_data", 64'({out_class, out_alu_a, out_alu_b, out_alu_dst, out_alu_op,
                                out_status_edit, out_uop_idx, out_uop_last}), 64'h0);

        // Flag op: one micro-op, visible the cycle after acceptance
        step(1'b1, 1'b0, 1'b1, 8'h0D, 1'b0, 3'b000, 2'b00, 4'h3, 1'b0);
        idle(1'b1);
        check("t1_valid", 64'(out_valid), 64'h1);
        check("t1_class", 64'(out_class), 64'h200);
        check("t1_idx_last", 64'({out_uop_idx, out_uop_last}), 64'b001);
        check("t1_status", 64'(out_status_edit), 64'h82);
        idle(1'b1);

        // JSR: three micro-ops back to back, in_ready low for two cycles
        step(1'b1, 1'b0, 1'b1, 8'h1D, 1'b0, 3'b000, 2'b01, 4'h5, 1'b0);
        for (int k = 0; k < 3; k++) begin
            idle(1'b1);
            check("t2_idx", 64'(out_uop_idx), 64'(k));
            check("t2_last", 64'(out_uop_last), 64'(k == 2));
            check("t2_ready", 64'(in_ready), 64'(k == 2));
        end
        idle(1'b1);

        // Back-pressure: FIFO fills after two single-uop ops
        step(1'b1, 1'b0, 1'b0, 8'h18, 1'b0, 3'b000, 2'b00, 4'h1, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 3'b000, 2'b00, 4'h2, 1'b0);
        step(1'b1, 1'b0, 1'b0, 8'h2E, 1'b0, 3'b000, 2'b00, 4'h3, 1'b0);
        check("t3_full_ready", 64'(in_ready), 64'h0);
        step(1'b1, 1'b0, 1'b1, 8'h2E, 1'b0, 3'b000, 2'b00, 4'h3, 1'b0);
        check("t3_head0", 64'(out_alu_op), 64'h1);
        step(1'b1, 1'b0, 1'b1, 8'h2E, 1'b0, 3'b000, 2'b00, 4'h3, 1'b0);
        check("t3_head1", 64'(out_alu_op), 64'h2);
        idle(1'b1);
        check("t3_head2", 64'(out_alu_op), 64'h3);
        idle(1'b1);

        // ALU B source selection
        step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 3'b000, 2'b01, 4'h0, 1'b1);
        step(1'b1, 1'b0, 1'b1, 8'h40, 1'b1, 3'b010, 2'b01, 4'h0, 1'b0);
        check("t4_imm", 64'({out_alu_a, out_alu_b}), 64'h0208);
        step(1'b1, 1'b0, 1'b1, 8'h40, 1'b0, 3'b011, 2'b10, 4'h0, 1'b0);
        check("t4_memload", 64'({out_alu_a, out_alu_b, out_alu_dst}), 64'h020102);
        idle(1'b1);
        check("t4_one", 64'({out_alu_a, out_alu_b, out_alu_dst}), 64'h030703);
        idle(1'b1);

        // BRK flushed while idx 2 is still pending
        step(1'b1, 1'b0, 1'b0, 8'h0C, 1'b0, 3'b000, 2'b00, 4'h7, 1'b0);
        idle(1'b0);
        step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'b000, 2'b00, 4'h0, 1'b0);
        idle(1'b1);
        check("t5_valid", 64'(out_valid), 64'h0);
        check("t5_ready", 64'(in_ready), 64'h1);
        repeat (3) idle(1'b1);

        // Reset in the middle of an expansion
        step(1'b1, 1'b0, 1'b0, 8'h1D, 1'b1, 3'b001, 2'b00, 4'h9, 1'b0);
        idle(1'b0);
        mid_reset();
        idle(1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            v    = ($urandom_range(0, 9) < 7);
            fl   = ($urandom_range(0, 49) == 0);
            ordy = ($urandom_range(0, 9) < 6);
            op   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                               : op_tab[$urandom_range(0, 25)];
            mem  = 1'($urandom_range(0, 1));
            imm  = ($urandom_range(0, 3) == 0);
            step(v, fl, ordy, op, mem, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                 4'($urandom_range(0, 15)), imm);
        end
        repeat (8) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
